instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction producer for the RV32I core: owns the PC and fetches one word at a time
//  from instruction memory (variable latency, one outstanding request).
//  Presents each word plus its PC to the decode/control stage with a valid/ready handshake.
//  Takes that stage's PCSrc, ImmExt and ALU result back to pick the next PC:
//  sequential, branch/JAL, or JALR.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC of first fetch after reset
//  TIMEOUT_CYC   16             max cycles waiting for imem_valid before fetch_err
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous reset, active low
//  imem_req     out  1   request strobe; held high until imem_valid
//  imem_addr    out  32  word address of request (= pc), stable while imem_req=1
//  imem_rdata   in   32  returned instruction word
//  imem_valid   in   1   imem_rdata valid this cycle; ignored unless in S_REQ
//  instr        out  32  fetched instruction to control unit
//  instr_pc     out  32  PC of instr
//  instr_valid  out  1   instr/instr_pc valid
//  instr_ready  in   1   downstream consumes instr when valid&ready
//  pc_src       in   2   00 PC+4, 01 PC+imm_ext, 10 {alu_result[31:1],1'b0}, 11 reserved
//  imm_ext      in   32  sign-extended B/J immediate of consumed instr
//  alu_result   in   32  JALR target (rs1+imm) of consumed instr
//  fetch_err    out  1   sticky error: timeout, misaligned target, or pc_src=11
// BEHAVIOUR
//  Reset (async, rst_n=0) values:
//   state=S_IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=0,
//   instr_pc=RESET_PC, instr_valid=0, fetch_err=0, timeout counter=0.
//  Outputs are Moore: registered, or decoded from state/pc only. No comb path imem_valid->instr_valid.
//  States:
//   S_IDLE: one cycle after reset release -> S_REQ.
//   S_REQ:  imem_req=1, imem_addr=pc. Counter increments each cycle.
//           imem_valid=1 -> instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, counter<=0, -> S_HOLD.
//           Counter reaches TIMEOUT_CYC-1 without imem_valid -> fetch_err<=1, -> S_ERR.
//   S_HOLD: instr_valid=1; instr/instr_pc held stable until instr_ready=1.
//           On valid&ready, in the same cycle:
//            - sample pc_src/imm_ext/alu_result
//            - next = pc+4 | instr_pc+imm_ext | alu_result&~1 (32-bit add, wraps mod 2^32)
//            - next[1:0]!=0 or pc_src=11 -> fetch_err<=1, -> S_ERR
//            - else pc<=next, instr_valid<=0, -> S_REQ
//   S_ERR:  imem_req=0, instr_valid=0, fetch_err=1. Terminal until rst_n asserted.
//  Throughput/latency:
//   - Memory latency L>=1 cycles (imem_valid L cycles after first imem_req cycle).
//   - instr_valid rises the cycle after imem_valid.
//   - Next imem_req rises the cycle after the consume.
//   - Best case: one instruction per L+2 cycles.
//  Boundaries:
//   - imem_valid in S_IDLE/S_HOLD/S_ERR is dropped; no capture, no state change.
//   - instr_ready=1 while instr_valid=0 has no effect.
//   - Sequential PC 32'hFFFF_FFFC + 4 wraps to 0 with no error.
//   - Reset mid-request abandons the request; first post-reset fetch is RESET_PC again.
// TESTING
//  1. Reset, 1-cycle mem, ready=1, pc_src=00:
//     imem_addr 0,4,8,... each request 3 cycles apart; instr/instr_pc match memory image.
//  2. Consume at pc=0x10 with pc_src=01, imm_ext=32'hFFFF_FFF8:
//     next imem_addr=0x08. Consume at pc=0x20 with pc_src=10, alu_result=0x0000_0105:
//     next imem_addr=0x104.
//  3. Backpressure: ready=0 for 5 cycles in S_HOLD; instr and instr_pc stay constant,
//     imem_req=0 throughout; single consume on ready=1.
//  4. imem_valid held 0 for TIMEOUT_CYC cycles -> fetch_err=1, imem_req=0 afterwards;
//     stays until rst_n pulse.
//  5. pc_src=01 with imm_ext=2 -> fetch_err=1 (misaligned); pc_src=11 -> fetch_err=1.
//  6. rst_n low while in S_REQ at pc=0x40 -> outputs return to reset values immediately;
//     after release the first imem_addr is RESET_PC; a stray imem_valid in S_IDLE is ignored.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RV32I instruction fetch unit with single-outstanding imem requests
// Purpose: owns the PC, fetches one word at a time from variable-latency instruction
//          memory and hands each word plus its PC to decode over a valid/ready handshake.
//          The consuming stage returns pc_src/imm_ext/alu_result to select the next PC.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/imem_addr         request strobe and word address (= pc)
//   imem_rdata/imem_valid      returned word and its strobe (only honoured while requesting)
//   instr/instr_pc/instr_valid fetched word, its PC, and valid towards decode
//   instr_ready                decode accepts instr when valid&ready
//   pc_src/imm_ext/alu_result  next-PC selection from the consumed instruction
//   fetch_err                  sticky error: timeout, misaligned target or reserved pc_src
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  output logic        fetch_err
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TCNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_ERR} state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [CW-1:0]   tcnt;
  logic [31:0]     next_pc;
  logic            next_bad;

  // Request strobe and address are decoded from state/pc so they never depend on imem_valid.
  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;

  // Target of the instruction being consumed; only meaningful in S_HOLD with instr_ready.
  always_comb begin
    next_pc = pc + 32'd4;
    case (pc_src)
      2'b00:   next_pc = pc + 32'd4;
      2'b01:   next_pc = instr_pc + imm_ext;
      2'b10:   next_pc = alu_result & 32'hFFFF_FFFE;
      default: next_pc = pc + 32'd4;
    endcase
    next_bad = (pc_src == 2'b11) || (next_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      tcnt        <= '0;
      instr       <= 32'd0;
      instr_pc    <= RESET_PC;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;

        S_REQ: begin
          if (imem_valid) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            tcnt        <= '0;
            state       <= S_HOLD;
          end else if (tcnt == TCNT_LAST) begin
            fetch_err <= 1'b1;
            tcnt      <= '0;
            state     <= S_ERR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        S_HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (next_bad) begin
              fetch_err <= 1'b1;
              state     <= S_ERR;
            end else begin
              pc    <= next_pc;
              state <= S_REQ;
            end
          end
        end

        S_ERR: begin
          instr_valid <= 1'b0;
          fetch_err   <= 1'b1;
        end

        default: state <= S_ERR;
      endcase
    end
  end

endmodule
